// File: rtl/noise_gate_ahr.sv
// -----------------------------------------------------------------------------
// noise_gate_ahr
//
// Second-generation noise gate placed between the mic deserialiser and the
// effects chain. Instead of a 0/1 pass flag, every sample is scaled by a gain
// that ramps up (attack) and down (release). An envelope follower on |in|
// drives an open/close decision with hysteresis and a hold timer.
//
// Two-stage pipeline, one sample per in_valid strobe:
//   stage 1 (_p1): |in| with saturation, envelope update, sample capture
//   stage 2 (_p2): FSM/gain update on the new envelope, output scaling
//
// Build option:
//   NOISE_GATE_RAMP_EN defined   : CLOSED -> ATTACK -> OPEN -> HOLD -> RELEASE
//   NOISE_GATE_RAMP_EN undefined : CLOSED -> OPEN -> HOLD -> CLOSED, gain jumps
//                                  straight between 0 and unity
//
// Ports:
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous reset, active low
//   in         in   WIDTH  signed input sample
//   in_valid   in   1      one-cycle sample strobe, may be high every cycle
//   out        out  WIDTH  signed gated sample
//   out_valid  out  1      one-cycle strobe, two cycles after in_valid
//   gate_open  out  1      high whenever the gate is not CLOSED
// -----------------------------------------------------------------------------
module noise_gate_ahr #(
  parameter int WIDTH        = 16,
  parameter int ENV_SHIFT    = 2,
  parameter int OPEN_THRESH  = 5000,
  parameter int CLOSE_THRESH = 4000,
  parameter int HOLD_SAMPLES = 4800,
  parameter int GAIN_BITS    = 8,
  parameter int ATTACK_STEP  = 32,
  parameter int RELEASE_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    in_valid,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid,
  output logic                    gate_open
);

  localparam int GW = GAIN_BITS + 1;
  localparam int HW = $clog2(HOLD_SAMPLES + 1);
  localparam int PW = WIDTH + GAIN_BITS + 1;

  localparam logic signed [WIDTH-1:0] SMIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic        [WIDTH-1:0] SMAX  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic        [GW-1:0]    UNITY = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic        [WIDTH-1:0] OPEN_LVL  = WIDTH'(OPEN_THRESH);
  localparam logic        [WIDTH-1:0] CLOSE_LVL = WIDTH'(CLOSE_THRESH);
  localparam logic        [HW-1:0]    HOLD_INIT = HW'(HOLD_SAMPLES - 1);

  // Reject configurations the FSM cannot honour (inverted hysteresis band,
  // zero-length hold, ramps that never move).
  if (CLOSE_THRESH > OPEN_THRESH || HOLD_SAMPLES < 1 ||
      ATTACK_STEP < 1 || RELEASE_STEP < 1) begin : g_bad_cfg
    $error("noise_gate_ahr: invalid parameter set");
  end

`ifdef NOISE_GATE_RAMP_EN
  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // |x| with the most negative code folded onto the most positive one.
  function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
    if (x == SMIN) return SMAX;
    if (x[WIDTH-1]) return WIDTH'(-x);
    return WIDTH'(x);
  endfunction

  // One-pole smoother: env + (abs - env) / 2^ENV_SHIFT, with a floor shift.
  // The difference needs one extra bit; the result stays within [0, SMAX].
  function automatic logic [WIDTH-1:0] env_step(input logic [WIDTH-1:0] e,
                                                input logic [WIDTH-1:0] a);
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] sum;
    diff = $signed({1'b0, a}) - $signed({1'b0, e});
    sum  = $signed({1'b0, e}) + (diff >>> ENV_SHIFT);
    return WIDTH'(sum);
  endfunction

  // (x * g) >>> GAIN_BITS, truncated. With g = UNITY this is the identity,
  // including the most negative input code.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] x,
                                                    input logic [GW-1:0] g);
    logic signed [PW-1:0] xa;
    logic signed [PW-1:0] ga;
    logic signed [PW-1:0] prod;
    xa   = PW'(x);
    ga   = $signed(PW'(g));
    prod = xa * ga;
    return WIDTH'(prod >>> GAIN_BITS);
  endfunction

`ifdef NOISE_GATE_RAMP_EN
  // Gain increment, saturating at unity.
  function automatic logic [GW-1:0] gain_up(input logic [GW-1:0] g);
    logic [GW:0] s;
    s = {1'b0, g} + (GW+1)'(ATTACK_STEP);
    if (s >= {1'b0, UNITY}) return UNITY;
    return GW'(s);
  endfunction

  // Gain decrement, floored at zero.
  function automatic logic [GW-1:0] gain_down(input logic [GW-1:0] g);
    if (g <= GW'(RELEASE_STEP)) return '0;
    return g - GW'(RELEASE_STEP);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic                    vld_p1;
  logic                    vld_p2;
  logic signed [WIDTH-1:0] in_p1;
  logic        [WIDTH-1:0] env;

  state_t                  state;
  state_t                  state_n;
  logic        [GW-1:0]    gain;
  logic        [GW-1:0]    gain_n;
  logic        [HW-1:0]    hold_cnt;
  logic        [HW-1:0]    hold_n;

  logic                    env_hi;
  logic                    env_lo;

  // ---- stage 1: rectify, smooth, capture sample ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      env    <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) env <= env_step(env, abs_sat(in));
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) in_p1 <= in;
  end

  // ---- stage 2: gate decision on the freshly updated envelope ----
  assign env_hi = (env > OPEN_LVL);
  assign env_lo = (env < CLOSE_LVL);

  always_comb begin
    state_n = state;
    gain_n  = gain;
    hold_n  = hold_cnt;
    case (state)
      CLOSED: begin
        gain_n = '0;
        if (env_hi) begin
`ifdef NOISE_GATE_RAMP_EN
          gain_n  = gain_up('0);
          state_n = (gain_n == UNITY) ? OPEN : ATTACK;
`else
          gain_n  = UNITY;
          state_n = OPEN;
`endif
        end
      end
`ifdef NOISE_GATE_RAMP_EN
      // Envelope is deliberately ignored here: an attack always completes.
      ATTACK: begin
        gain_n = gain_up(gain);
        if (gain_n == UNITY) state_n = OPEN;
      end
`endif
      OPEN: begin
        gain_n = UNITY;
        if (env_lo) begin
          state_n = HOLD;
          hold_n  = HOLD_INIT;
        end
      end
      // A re-trigger wins over expiry on the same sample.
      HOLD: begin
        gain_n = UNITY;
        if (env_hi) begin
          state_n = OPEN;
          hold_n  = '0;
        end else if (hold_cnt == '0) begin
`ifdef NOISE_GATE_RAMP_EN
          gain_n  = gain_down(UNITY);
          state_n = (gain_n == '0) ? CLOSED : RELEASE;
`else
          gain_n  = '0;
          state_n = CLOSED;
`endif
        end else begin
          hold_n = hold_cnt - 1'b1;
        end
      end
`ifdef NOISE_GATE_RAMP_EN
      // A re-trigger resumes the attack from the current gain, so no step.
      RELEASE: begin
        if (env_hi) begin
          gain_n  = gain_up(gain);
          state_n = (gain_n == UNITY) ? OPEN : ATTACK;
        end else begin
          gain_n = gain_down(gain);
          if (gain_n == '0) state_n = CLOSED;
        end
      end
`endif
      default: begin
        state_n = CLOSED;
        gain_n  = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLOSED;
      gain     <= '0;
      hold_cnt <= '0;
    end else if (vld_p1) begin
      state    <= state_n;
      gain     <= gain_n;
      hold_cnt <= hold_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      out    <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) out <= scale(in_p1, gain_n);
    end
  end

  assign out_valid = vld_p2;
  assign gate_open = (state != CLOSED);

endmodule

// File: tb/tb_noise_gate_ahr.sv
// -----------------------------------------------------------------------------
// tb_noise_gate_ahr
//
// Directed bench for noise_gate_ahr (HOLD_SAMPLES = 4). A behavioural integer
// model predicts each sample's output, gate state and arrival cycle when the
// sample is driven; the prediction is queued and checked when out_valid rises.
// The model follows whichever build NOISE_GATE_RAMP_EN selects.
// -----------------------------------------------------------------------------
module tb_noise_gate_ahr;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] in_s = '0;
  logic               in_valid = 1'b0;
  logic signed [15:0] out_s;
  logic               out_valid;
  logic               gate_open;

  always #5 clk = ~clk;

  noise_gate_ahr #(
    .HOLD_SAMPLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in_s),
    .in_valid (in_valid),
    .out      (out_s),
    .out_valid(out_valid),
    .gate_open(gate_open)
  );

  typedef struct {
    int val;
    bit gopen;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---- reference model ----
  localparam int M_CLOSED = 0, M_ATTACK = 1, M_OPEN = 2, M_HOLD = 3, M_REL = 4;
  int m_env, m_st, m_gain, m_hold;

  function automatic void model_reset();
    m_env  = 0;
    m_st   = M_CLOSED;
    m_gain = 0;
    m_hold = 0;
  endfunction

  function automatic void model_step(input int x, input int now);
    int a;
    bit hi, lo;
    exp_t e;
    a = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
    m_env = m_env + ((a - m_env) >>> 2);
    hi = (m_env > 5000);
    lo = (m_env < 4000);
`ifdef NOISE_GATE_RAMP_EN
    case (m_st)
      M_CLOSED: if (hi) begin m_gain = 32; m_st = M_ATTACK; end
      M_ATTACK: begin
        m_gain = m_gain + 32;
        if (m_gain >= 256) begin m_gain = 256; m_st = M_OPEN; end
      end
      M_OPEN: if (lo) begin m_st = M_HOLD; m_hold = 3; end
      M_HOLD: begin
        if (hi) m_st = M_OPEN;
        else if (m_hold == 0) begin m_gain = 255; m_st = M_REL; end
        else m_hold = m_hold - 1;
      end
      default: begin
        if (hi) begin
          m_gain = m_gain + 32;
          if (m_gain >= 256) begin m_gain = 256; m_st = M_OPEN; end
          else m_st = M_ATTACK;
        end else begin
          m_gain = m_gain - 1;
          if (m_gain == 0) m_st = M_CLOSED;
        end
      end
    endcase
`else
    case (m_st)
      M_CLOSED: if (hi) begin m_gain = 256; m_st = M_OPEN; end
      M_OPEN:   if (lo) begin m_st = M_HOLD; m_hold = 3; end
      default: begin
        if (hi) m_st = M_OPEN;
        else if (m_hold == 0) begin m_gain = 0; m_st = M_CLOSED; end
        else m_hold = m_hold - 1;
      end
    endcase
`endif
    e.val   = (x * m_gain) >>> 8;
    e.gopen = (m_st != M_CLOSED);
    e.cyc   = now + 2;
    sbq.push_back(e);
  endfunction

  // ---- stimulus helpers ----
  task automatic send(input int x);
    @(posedge clk);
    #1;
    in_s     = 16'(x);
    in_valid = 1'b1;
    model_step(x, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_n(input int x, input int n);
    repeat (n) send(x);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_vec++;
    assert (out_s === 16'sd0) else begin
      n_err++; $error("FAIL %s out: got %0d want 0", tag, out_s);
    end
    n_vec++;
    assert (out_valid === 1'b0) else begin
      n_err++; $error("FAIL %s out_valid: got %b want 0", tag, out_valid);
    end
    n_vec++;
    assert (gate_open === 1'b0) else begin
      n_err++; $error("FAIL %s gate_open: got %b want 0", tag, gate_open);
    end
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    sbq.delete();
    model_reset();
    @(negedge clk);
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---- output monitor ----
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        n_vec++;
        assert (sbq.size() != 0) else begin
          n_err++; $error("FAIL spurious_valid: got out_valid=1 at cycle %0d want none", cyc);
        end
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          n_vec++;
          assert (cyc === e.cyc) else begin
            n_err++; $error("FAIL latency: got cycle %0d want %0d", cyc, e.cyc);
          end
          n_vec++;
          assert (out_s === 16'(e.val)) else begin
            n_err++; $error("FAIL out: got %0d want %0d (cycle %0d)", out_s, e.val, cyc);
          end
          n_vec++;
          assert (gate_open === e.gopen) else begin
            n_err++; $error("FAIL gate_open: got %b want %b (cycle %0d)", gate_open, e.gopen, cyc);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        n_vec++;
        assert (out_valid === 1'b1) else begin
          n_err++; $error("FAIL missing_valid: got out_valid=0 at cycle %0d want 1", cyc);
        end
        void'(sbq.pop_front());
      end
    end
  end

  // ---- watchdog ----
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---- directed sequence ----
  initial begin
    model_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // loud signal from reset: envelope build-up and attack ramp
    send_n(10000, 12);

    // quiet signal: open, hold, release down to closed
    send_n(100, 270);

    // re-trigger mid-hold
    send_n(10000, 6);
    send_n(100, 5);
    send_n(10000, 4);

    // re-trigger mid-release
    send_n(100, 64);
    send_n(10000, 8);

    // most negative sample at unity gain, with gaps between samples
    repeat (6) begin
      send(-32768);
      idle(3);
    end

    // mixed random samples with random gaps
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 65535)) - 32768);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    // reset during the attack, then a clean restart
    apply_reset("rst_idle");
    send_n(10000, 5);
    apply_reset("rst_attack");
    send_n(10000, 12);
    send_n(100, 30);
    idle(2);

    // drain with a bounded wait
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(posedge clk);
    n_vec++;
    assert (sbq.size() == 0) else begin
      n_err++; $error("FAIL drain: got %0d pending outputs want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
